prewish5k_button_conditioner: RTL and testbench
===============================================

PREWISH5K_BUTTON_CONDITIONER -- requirements
Module: prewish5k_button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_BITS, default 16, giving the debounce counter width; the debounce interval is 2^DEBOUNCE_BITS cycles.
REQ-002 The block SHALL have parameter LOCKOUT_BITS, default 20, giving the post-release lockout counter width; the lockout interval is 2^LOCKOUT_BITS cycles.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port RST_I, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_button_n, input, 1 bit: raw active-low pushbutton, asynchronous to i_clk.
REQ-006 The block SHALL have port i_dip_n, input, 8 bits: raw active-low DIP switches, asynchronous to i_clk.
REQ-007 The block SHALL have port o_button, output, 1 bit: debounced active-high button level for the controller's button_internal input.
REQ-008 The block SHALL have port STB_O, output, 1 bit: one-cycle strobe that marks a new mask on DAT_O.
REQ-009 The block SHALL have port DAT_O, output, 8 bits: active-high blink mask, the inverse of the synchronized i_dip_n.
REQ-010 The block SHALL have port o_busy, output, 1 bit: high while in LOCKOUT.

Function
REQ-011 i_button_n and each i_dip_n bit SHALL pass through a 2-flop synchronizer. Internal signal btn is the inverse of the button synchronizer's second stage.
REQ-012 The FSM SHALL have the states IDLE, PRESS_DB, HELD, RELEASE_DB and LOCKOUT, and a single shared counter that is cleared on every state entry.
REQ-013 IDLE: when btn=1, the FSM SHALL go to PRESS_DB; otherwise it stays in IDLE.
REQ-014 PRESS_DB:
- When btn=0, the FSM SHALL go to IDLE (bounce rejected).
- Otherwise the counter increments.
- When the counter equals 2^DEBOUNCE_BITS-1 and btn=1, the FSM SHALL go to HELD.
REQ-015 On the PRESS_DB->HELD transition, the block SHALL register the following, visible the next cycle:
- STB_O=1 for exactly one cycle;
- DAT_O = ~(dip synchronizer output) sampled on that same edge;
- o_button=1.
REQ-016 HELD: o_button SHALL stay 1. When btn=0, the FSM SHALL go to RELEASE_DB.
REQ-017 RELEASE_DB:
- When btn=1, the FSM SHALL return to HELD, with no strobe and o_button unchanged.
- Otherwise the counter increments.
- At 2^DEBOUNCE_BITS-1 with btn=0, the FSM SHALL go to LOCKOUT and o_button SHALL go to 0.
REQ-018 LOCKOUT: btn SHALL be ignored and o_busy=1. The counter increments every cycle. At 2^LOCKOUT_BITS-1 the FSM SHALL go to IDLE.
REQ-019 Press latency: when the raw falling edge is first sampled on edge r, STB_O SHALL be high in the cycle after edge r+3+2^DEBOUNCE_BITS, assuming a clean press.
REQ-020 Counters SHALL never wrap: each terminal count forces a state exit, and the counter is cleared on entry to the next state.
REQ-021 DAT_O SHALL hold its value until the next STB_O. DIP changes without a qualified press SHALL have no effect on any output.
REQ-022 STB_O SHALL pulse at most once per press, regardless of how long the press is held or how much it bounces.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 While RST_I=1, the block SHALL asynchronously force the following, regardless of state or i_clk:
- state=IDLE;
- counter=0;
- button synchronizer flops=1 (released);
- DIP synchronizer flops=8'hFF;
- o_button=0, STB_O=0, DAT_O=8'h00, o_busy=0.
REQ-025 When reset is asserted mid-press, mid-debounce or mid-lockout, it SHALL abort the operation with no strobe. After deassertion, a button still held SHALL be treated as a new press from IDLE.

Verification (DEBOUNCE_BITS=4, LOCKOUT_BITS=6)
REQ-026 Clean press: i_dip_n=8'b01011111, i_button_n low for 40 cycles -> exactly one STB_O pulse 19 cycles after the sampling edge, DAT_O=8'hA0, and o_button=1 until release debounce completes.
REQ-027 Press bounce: i_button_n low 5 cycles, high 3, then low held -> exactly one STB_O, timed 19 cycles from the start of the final low.
REQ-028 Release bounce: in HELD, i_button_n high 6 cycles, then low -> o_button stays 1, no STB_O, state returns to HELD.
REQ-029 Lockout:
- Release, then press 10 cycles into lockout for 20 cycles -> o_busy=1, no STB_O, DAT_O unchanged.
- Then set i_dip_n=8'b00110011 and press after lockout ends -> STB_O once, DAT_O=8'hCC.
REQ-030 Reset: assert RST_I asynchronously (between clock edges) while in HELD -> o_button, STB_O, DAT_O and o_busy read 0 immediately. Release RST_I with the button still held -> new STB_O 19 cycles later.

Source files
------------

// File: rtl/prewish5k_button_conditioner.sv
// Pushbutton and DIP-switch conditioner: synchronizes raw inputs, debounces press and
// release, strobes out the DIP mask once per qualified press and locks out re-triggering.
module prewish5k_button_conditioner #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int LOCKOUT_BITS  = 20
) (
  input  logic       i_clk,
  input  logic       RST_I,
  input  logic       i_button_n,
  input  logic [7:0] i_dip_n,
  output logic       o_button,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic       o_busy
);

  localparam int CNT_BITS = (DEBOUNCE_BITS > LOCKOUT_BITS) ? DEBOUNCE_BITS : LOCKOUT_BITS;
  localparam logic [CNT_BITS-1:0] DB_MAX = CNT_BITS'({DEBOUNCE_BITS{1'b1}});
  localparam logic [CNT_BITS-1:0] LO_MAX = CNT_BITS'({LOCKOUT_BITS{1'b1}});

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PRESS_DB   = 3'd1;
  localparam logic [2:0] S_HELD       = 3'd2;
  localparam logic [2:0] S_RELEASE_DB = 3'd3;
  localparam logic [2:0] S_LOCKOUT    = 3'd4;

  logic                btn_meta;
  logic                btn_sync;
  logic                btn;
  logic [7:0]          dip_meta;
  logic [7:0]          dip_sync;
  logic [2:0]          state;
  logic [CNT_BITS-1:0] cnt;

  // Two-flop synchronizers; btn is registered so a clean press strobes 2^DEBOUNCE_BITS+3 edges after sampling
  always_ff @(posedge i_clk or posedge RST_I) begin
    if (RST_I) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      btn      <= 1'b0;
      dip_meta <= 8'hFF;
      dip_sync <= 8'hFF;
    end else begin
      btn_meta <= i_button_n;
      btn_sync <= btn_meta;
      btn      <= ~btn_sync;
      dip_meta <= i_dip_n;
      dip_sync <= dip_meta;
    end
  end

  always_ff @(posedge i_clk or posedge RST_I) begin
    if (RST_I) begin
      state    <= S_IDLE;
      cnt      <= '0;
      o_button <= 1'b0;
      STB_O    <= 1'b0;
      DAT_O    <= 8'h00;
      o_busy   <= 1'b0;
    end else begin
      STB_O <= 1'b0;
      case (state)
        S_IDLE: begin
          if (btn) begin
            state <= S_PRESS_DB;
            cnt   <= '0;
          end
        end
        S_PRESS_DB: begin
          if (!btn) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == DB_MAX) begin
            state    <= S_HELD;
            cnt      <= '0;
            STB_O    <= 1'b1;
            DAT_O    <= ~dip_sync;
            o_button <= 1'b1;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        S_HELD: begin
          if (!btn) begin
            state <= S_RELEASE_DB;
            cnt   <= '0;
          end
        end
        S_RELEASE_DB: begin
          // A bounce back to pressed returns to HELD silently; only a stable release ends the press
          if (btn) begin
            state <= S_HELD;
            cnt   <= '0;
          end else if (cnt == DB_MAX) begin
            state    <= S_LOCKOUT;
            cnt      <= '0;
            o_button <= 1'b0;
            o_busy   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        S_LOCKOUT: begin
          if (cnt == LO_MAX) begin
            state  <= S_IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          o_button <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prewish5k_button_conditioner.sv
// Bench for prewish5k_button_conditioner: a run-length reference model predicts strobes,
// which a negedge monitor pops and compares along with the level outputs.
module tb_prewish5k_button_conditioner;

  localparam int DB        = 4;
  localparam int LB        = 6;
  localparam int PRESS_RUN = (1 << DB) + 1;
  localparam int LOCK_RUN  = 1 << LB;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       btnN = 1'b1;
  logic [7:0] dipN = 8'hFF;
  logic       oButton;
  logic       stb;
  logic [7:0] dat;
  logic       busy;

  prewish5k_button_conditioner #(.DEBOUNCE_BITS(DB), .LOCKOUT_BITS(LB)) dut (
    .i_clk     (clk),
    .RST_I     (rst),
    .i_button_n(btnN),
    .i_dip_n   (dipN),
    .o_button  (oButton),
    .STB_O     (stb),
    .DAT_O     (dat),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  data;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  int         edgeCount = 0;
  exp_t       expQ[$];
  logic       rawQ[$];
  logic [7:0] dipQ[$];
  int         mode;
  int         run;
  logic [7:0] modelData;
  logic       seen;
  logic [7:0] dipSeen;
  exp_t       pushE;
  exp_t       popE;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  // Reference model: mode 0 ready, 1 held, 2 lockout; phases end after runs of stable samples
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rawQ = {};
      dipQ = {};
      repeat (3) rawQ.push_back(1'b1);
      repeat (2) dipQ.push_back(8'hFF);
      mode = 0;
      run = 0;
      modelData = 8'h00;
      expQ.delete();
    end else begin
      edgeCount++;
      seen = ~rawQ.pop_front();
      rawQ.push_back(btnN);
      dipSeen = dipQ.pop_front();
      dipQ.push_back(dipN);
      case (mode)
        0: begin
          if (seen) begin
            run++;
            if (run == PRESS_RUN) begin
              modelData = ~dipSeen;
              pushE.cyc = edgeCount;
              pushE.data = ~dipSeen;
              expQ.push_back(pushE);
              mode = 1;
              run = 0;
            end
          end else begin
            run = 0;
          end
        end
        1: begin
          if (!seen) begin
            run++;
            if (run == PRESS_RUN) begin
              mode = 2;
              run = 0;
            end
          end else begin
            run = 0;
          end
        end
        default: begin
          run++;
          if (run == LOCK_RUN) begin
            mode = 0;
            run = 0;
          end
        end
      endcase
    end
  end

  // Monitor: pops an expected strobe whenever the DUT strobes, flags late or spurious ones
  always @(negedge clk) begin
    if (!rst) begin
      if (stb) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious strobe", 32'd1, 32'd0);
        end else begin
          popE = expQ.pop_front();
          checkOutput("strobe cycle", edgeCount, popE.cyc);
          checkOutput("strobe data", 32'(dat), 32'(popE.data));
        end
      end else if (expQ.size() > 0 && expQ[0].cyc <= edgeCount) begin
        popE = expQ.pop_front();
        checkOutput("missed strobe", 32'd0, 32'd1);
      end
      checkOutput("o_button", 32'(oButton), 32'(mode == 1));
      checkOutput("o_busy", 32'(busy), 32'(mode == 2));
      checkOutput("DAT_O hold", 32'(dat), 32'(modelData));
    end
  end

  task automatic applyStimulus(input logic b, input logic [7:0] d, input int n);
    btnN = b;
    dipN = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset o_button", 32'(oButton), 32'd0);
    checkOutput("reset STB_O", 32'(stb), 32'd0);
    checkOutput("reset DAT_O", 32'(dat), 32'd0);
    checkOutput("reset o_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Clean press
    applyStimulus(1'b0, 8'b01011111, 40);
    applyStimulus(1'b1, 8'b01011111, 150);
    checkOutput("clean press mask", 32'(dat), 32'hA0);

    // Press bounce
    applyStimulus(1'b0, 8'h5A, 5);
    applyStimulus(1'b1, 8'h5A, 3);
    applyStimulus(1'b0, 8'h5A, 40);
    applyStimulus(1'b1, 8'h5A, 150);

    // Release bounce while held
    applyStimulus(1'b0, 8'h0F, 30);
    applyStimulus(1'b1, 8'h0F, 6);
    applyStimulus(1'b0, 8'h0F, 20);
    checkOutput("release bounce o_button", 32'(oButton), 32'd1);
    applyStimulus(1'b1, 8'h0F, 150);

    // Press during lockout is ignored, then a press after lockout takes the new mask
    applyStimulus(1'b0, 8'h3C, 25);
    applyStimulus(1'b1, 8'h3C, 30);
    applyStimulus(1'b0, 8'h81, 20);
    checkOutput("lockout busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 8'h81, 60);
    applyStimulus(1'b0, 8'b00110011, 25);
    checkOutput("post-lockout mask", 32'(dat), 32'hCC);
    applyStimulus(1'b1, 8'b00110011, 150);

    // Asynchronous reset while held, button kept pressed through release of reset
    applyStimulus(1'b0, 8'h77, 25);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async reset o_button", 32'(oButton), 32'd0);
    checkOutput("async reset STB_O", 32'(stb), 32'd0);
    checkOutput("async reset DAT_O", 32'(dat), 32'd0);
    checkOutput("async reset o_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    applyStimulus(1'b0, 8'h77, 30);
    checkOutput("post-reset mask", 32'(dat), 32'h88);
    applyStimulus(1'b1, 8'h77, 150);

    // Randomized button runs and DIP changes
    repeat (40) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 40)));
    end
    applyStimulus(1'b1, 8'hFF, 200);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
